// File: rtl/ula_issue.sv
// Execute-stage issue register feeding the ULA: decodes one RV32I instruction per
// handshake into ULA select and operands, behind a two-entry skid buffer.
module ula_issue #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush_in,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [6:0]       opcode_in,
  input  logic [2:0]       funct3_in,
  input  logic             funct7b5_in,
  input  logic [WIDTH-1:0] rs1_data_in,
  input  logic [WIDTH-1:0] rs2_data_in,
  input  logic [WIDTH-1:0] imm_in,
  input  logic [WIDTH-1:0] pc_in,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [WIDTH-1:0] data1_out,
  output logic [WIDTH-1:0] data2_out,
  output logic [3:0]       select_ula_out,
  output logic             illegal_out
);
  localparam logic [3:0] ULA_NOP  = 4'b0000;
  localparam logic [3:0] ULA_ADD  = 4'b0001;
  localparam logic [3:0] ULA_SUB  = 4'b0010;
  localparam logic [3:0] ULA_SLL  = 4'b0011;
  localparam logic [3:0] ULA_SLT  = 4'b0100;
  localparam logic [3:0] ULA_SLTU = 4'b0101;
  localparam logic [3:0] ULA_SRL  = 4'b0110;
  localparam logic [3:0] ULA_SRA  = 4'b0111;
  localparam logic [3:0] ULA_XOR  = 4'b1000;
  localparam logic [3:0] ULA_OR   = 4'b1001;
  localparam logic [3:0] ULA_AND  = 4'b1010;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam int             EW       = 2 * WIDTH + 5;
  localparam logic [WIDTH-1:0] LINK_OFS = WIDTH'(4);

  logic [3:0]       base_sel;
  logic [3:0]       dec_sel;
  logic [WIDTH-1:0] dec_d1;
  logic [WIDTH-1:0] dec_d2;
  logic             dec_ill;
  logic [EW-1:0]    dec_e;
  logic [EW-1:0]    o_e;
  logic [EW-1:0]    s_e;
  logic             o_valid;
  logic             s_valid;
  logic             in_fire;
  logic             out_fire;

  // funct3 map shared by OP and OP-IMM; funct7b5 only distinguishes SRA here.
  always_comb begin
    case (funct3_in)
      3'b000:  base_sel = ULA_ADD;
      3'b001:  base_sel = ULA_SLL;
      3'b010:  base_sel = ULA_SLT;
      3'b011:  base_sel = ULA_SLTU;
      3'b100:  base_sel = ULA_XOR;
      3'b101:  base_sel = funct7b5_in ? ULA_SRA : ULA_SRL;
      3'b110:  base_sel = ULA_OR;
      default: base_sel = ULA_AND;
    endcase
  end

  always_comb begin
    dec_sel = ULA_NOP;
    dec_d1  = '0;
    dec_d2  = '0;
    dec_ill = 1'b0;
    case (opcode_in)
      OPC_OP: begin
        dec_d1  = rs1_data_in;
        dec_d2  = rs2_data_in;
        dec_sel = (funct3_in == 3'b000 && funct7b5_in) ? ULA_SUB : base_sel;
      end
      OPC_OP_IMM: begin
        dec_d1  = rs1_data_in;
        dec_d2  = imm_in;
        dec_sel = (funct3_in == 3'b000) ? ULA_ADD : base_sel;
        if (funct3_in == 3'b001 || funct3_in == 3'b101)
          dec_d2 = {{(WIDTH-5){1'b0}}, imm_in[4:0]};
        dec_ill = (funct3_in == 3'b001) && funct7b5_in;
      end
      OPC_LUI: begin
        dec_d2  = imm_in;
        dec_sel = ULA_ADD;
      end
      OPC_AUIPC: begin
        dec_d1  = pc_in;
        dec_d2  = imm_in;
        dec_sel = ULA_ADD;
      end
      OPC_LOAD, OPC_STORE: begin
        dec_d1  = rs1_data_in;
        dec_d2  = imm_in;
        dec_sel = ULA_ADD;
      end
      OPC_BRANCH: begin
        dec_d1 = rs1_data_in;
        dec_d2 = rs2_data_in;
        case (funct3_in[2:1])
          2'b00:   dec_sel = ULA_SUB;
          2'b10:   dec_sel = ULA_SLT;
          2'b11:   dec_sel = ULA_SLTU;
          default: dec_ill = 1'b1;
        endcase
      end
      OPC_JAL, OPC_JALR: begin
        dec_d1  = pc_in;
        dec_d2  = LINK_OFS;
        dec_sel = ULA_ADD;
      end
      default: dec_ill = 1'b1;
    endcase
    // Every illegal entry presents as a NOP with zero operands.
    if (dec_ill) begin
      dec_sel = ULA_NOP;
      dec_d1  = '0;
      dec_d2  = '0;
    end
  end

  assign dec_e = {dec_d1, dec_d2, dec_sel, dec_ill};

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid and payload hold steady until that transfer.
  assign ready_in = !s_valid;
  assign in_fire  = valid_in && ready_in;
  assign out_fire = o_valid && ready_out;

  // S is only ever occupied while O is, so draining S never races an input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_valid <= 1'b0;
      s_valid <= 1'b0;
      o_e     <= '0;
      s_e     <= '0;
    end else if (flush_in) begin
      o_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (!o_valid || out_fire) begin
      if (s_valid) begin
        o_e     <= s_e;
        o_valid <= 1'b1;
        s_valid <= 1'b0;
      end else if (in_fire) begin
        o_e     <= dec_e;
        o_valid <= 1'b1;
      end else begin
        o_valid <= 1'b0;
      end
    end else if (in_fire) begin
      s_e     <= dec_e;
      s_valid <= 1'b1;
    end
  end

  assign valid_out      = o_valid;
  assign data1_out      = o_e[EW-1 -: WIDTH];
  assign data2_out      = o_e[WIDTH+4 -: WIDTH];
  assign select_ula_out = o_e[4:1];
  assign illegal_out    = o_e[0];

endmodule

// File: tb/tb_ula_issue.sv
// Bench for ula_issue: directed vectors push hand-computed entries into a queue,
// a negedge monitor pops and compares every entry the DUT hands downstream.
module tb_ula_issue;
  localparam int W  = 32;
  localparam int EW = 2 * W + 5;

  logic         clk;
  logic         reset_n;
  logic         flush_in;
  logic         valid_in;
  logic         ready_in;
  logic [6:0]   opcode_in;
  logic [2:0]   funct3_in;
  logic         funct7b5_in;
  logic [W-1:0] rs1_data_in;
  logic [W-1:0] rs2_data_in;
  logic [W-1:0] imm_in;
  logic [W-1:0] pc_in;
  logic         valid_out;
  logic         ready_out;
  logic [W-1:0] data1_out;
  logic [W-1:0] data2_out;
  logic [3:0]   select_ula_out;
  logic         illegal_out;

  logic [EW-1:0] exp_q[$];
  int            pop_cyc[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc   = 0;

  ula_issue #(.WIDTH(W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .flush_in       (flush_in),
    .valid_in       (valid_in),
    .ready_in       (ready_in),
    .opcode_in      (opcode_in),
    .funct3_in      (funct3_in),
    .funct7b5_in    (funct7b5_in),
    .rs1_data_in    (rs1_data_in),
    .rs2_data_in    (rs2_data_in),
    .imm_in         (imm_in),
    .pc_in          (pc_in),
    .valid_out      (valid_out),
    .ready_out      (ready_out),
    .data1_out      (data1_out),
    .data2_out      (data2_out),
    .select_ula_out (select_ula_out),
    .illegal_out    (illegal_out)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] pk(input logic [W-1:0] d1, input logic [W-1:0] d2,
                                       input logic [3:0] sel, input logic ill);
    return {d1, d2, sel, ill};
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    if (reset_n && valid_out && ready_out) begin
      pop_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_entry", {data1_out, data2_out, select_ula_out, illegal_out}, '0);
        if ({data1_out, data2_out, select_ula_out, illegal_out} == '0) begin
          n_err++;
          $display("FAIL unexpected_entry: got zero entry expected none");
        end
      end else begin
        chk("entry", {data1_out, data2_out, select_ula_out, illegal_out}, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                          input logic [W-1:0] rs1, input logic [W-1:0] rs2,
                          input logic [W-1:0] imm, input logic [W-1:0] pc);
    opcode_in   = op;
    funct3_in   = f3;
    funct7b5_in = f7;
    rs1_data_in = rs1;
    rs2_data_in = rs2;
    imm_in      = imm;
    pc_in       = pc;
    valid_in    = 1'b1;
  endtask

  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                      input logic [W-1:0] rs1, input logic [W-1:0] rs2,
                      input logic [W-1:0] imm, input logic [W-1:0] pc,
                      input logic [EW-1:0] exp);
    int n;
    drive_in(op, f3, f7, rs1, rs2, imm, pc);
    n = 0;
    while (!ready_in && n < 50) begin
      idle(1);
      n++;
    end
    if (n == 50) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: ready_in stuck at 0 expected 1");
    end else begin
      exp_q.push_back(exp);
    end
    idle(1);
    valid_in = 1'b0;
  endtask

  initial begin
    int base;
    reset_n  = 1'b0;
    flush_in = 1'b0;
    valid_in = 1'b0;
    ready_out = 1'b1;
    drive_in(7'd0, 3'd0, 1'b0, '0, '0, '0, '0);
    valid_in = 1'b0;
    #3;
    chk("rst_valid_out", valid_out, 1'b0);
    chk("rst_ready_in", ready_in, 1'b1);
    chk("rst_outputs", {data1_out, data2_out, select_ula_out, illegal_out}, '0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    idle(1);

    // ADD then SUB back to back
    base = pop_cyc.size();
    send(7'b0110011, 3'b000, 1'b0, 32'h55555555, 32'hAAAAAAAA, '0, '0,
         pk(32'h55555555, 32'hAAAAAAAA, 4'b0001, 1'b0));
    send(7'b0110011, 3'b000, 1'b1, 32'h55555555, 32'hAAAAAAAA, '0, '0,
         pk(32'h55555555, 32'hAAAAAAAA, 4'b0010, 1'b0));
    idle(3);
    chk("add_sub_count", pop_cyc.size() - base, 2);
    if (pop_cyc.size() >= base + 2) chk("add_sub_consecutive", pop_cyc[base+1] - pop_cyc[base], 1);

    // SRAI, LUI, AUIPC and a spread of other formats
    send(7'b0010011, 3'b101, 1'b1, 32'h83800155, '0, 32'h00000404, '0,
         pk(32'h83800155, 32'h00000004, 4'b0111, 1'b0));
    send(7'b0110111, 3'b000, 1'b0, 32'hDEADBEEF, '0, 32'h12345000, '0,
         pk(32'h0, 32'h12345000, 4'b0001, 1'b0));
    send(7'b0010111, 3'b000, 1'b0, '0, '0, 32'h00001000, 32'h00000100,
         pk(32'h100, 32'h1000, 4'b0001, 1'b0));
    send(7'b1100011, 3'b110, 1'b0, 32'h5, 32'h7, 32'hFFFFFFF0, '0,
         pk(32'h5, 32'h7, 4'b0101, 1'b0));
    send(7'b1100011, 3'b011, 1'b0, 32'h5, 32'h7, '0, '0,
         pk(32'h0, 32'h0, 4'b0000, 1'b1));
    send(7'b0010011, 3'b001, 1'b1, 32'h1, '0, 32'h00000403, '0,
         pk(32'h0, 32'h0, 4'b0000, 1'b1));
    send(7'b0100011, 3'b010, 1'b0, 32'h1000, 32'h99, 32'hFFFFFFFC, '0,
         pk(32'h1000, 32'hFFFFFFFC, 4'b0001, 1'b0));
    send(7'b1100111, 3'b000, 1'b0, 32'h40, '0, 32'h8, 32'h00000300,
         pk(32'h300, 32'h4, 4'b0001, 1'b0));
    idle(3);

    // backpressure: A held, B skidded, C refused until drain
    ready_out = 1'b0;
    send(7'b0110011, 3'b100, 1'b0, 32'h0F0F0000, 32'h00FF00FF, '0, '0,
         pk(32'h0F0F0000, 32'h00FF00FF, 4'b1000, 1'b0));
    send(7'b0110011, 3'b111, 1'b0, 32'hF0F0F0F0, 32'h0000FFFF, '0, '0,
         pk(32'hF0F0F0F0, 32'h0000FFFF, 4'b1010, 1'b0));
    drive_in(7'b0010011, 3'b110, 1'b0, 32'h1234, '0, 32'hFFFFF800, '0);
    idle(1);
    chk("bp_ready_in_low", ready_in, 1'b0);
    idle(2);
    chk("bp_hold_valid", valid_out, 1'b1);
    chk("bp_hold_data1", data1_out, 32'h0F0F0000);
    chk("bp_ready_in_still_low", ready_in, 1'b0);
    base = pop_cyc.size();
    ready_out = 1'b1;
    send(7'b0010011, 3'b110, 1'b0, 32'h1234, '0, 32'hFFFFF800, '0,
         pk(32'h1234, 32'hFFFFF800, 4'b1001, 1'b0));
    idle(3);
    chk("bp_drain_count", pop_cyc.size() - base, 3);
    if (pop_cyc.size() >= base + 2) chk("bp_a_b_consecutive", pop_cyc[base+1] - pop_cyc[base], 1);

    // flush with O and S full and a live input
    ready_out = 1'b0;
    send(7'b0000011, 3'b010, 1'b0, 32'h2000, '0, 32'h8, '0,
         pk(32'h2000, 32'h8, 4'b0001, 1'b0));
    send(7'b1101111, 3'b000, 1'b0, '0, '0, 32'h40, 32'h200,
         pk(32'h200, 32'h4, 4'b0001, 1'b0));
    drive_in(7'b0110011, 3'b110, 1'b0, 32'h1, 32'h2, '0, '0);
    flush_in = 1'b1;
    idle(1);
    flush_in = 1'b0;
    valid_in = 1'b0;
    exp_q.delete();
    chk("flush_valid_out", valid_out, 1'b0);
    chk("flush_ready_in", ready_in, 1'b1);
    base = pop_cyc.size();
    ready_out = 1'b1;
    idle(3);
    chk("flush_nothing_emitted", pop_cyc.size() - base, 0);
    send(7'b1111111, 3'b000, 1'b0, 32'h11, 32'h22, 32'h33, 32'h44,
         pk(32'h0, 32'h0, 4'b0000, 1'b1));
    idle(3);

    // asynchronous reset with O and S full
    ready_out = 1'b0;
    send(7'b0110011, 3'b001, 1'b0, 32'h3, 32'h4, '0, '0, pk(32'h3, 32'h4, 4'b0011, 1'b0));
    send(7'b0110011, 3'b010, 1'b0, 32'h5, 32'h6, '0, '0, pk(32'h5, 32'h6, 4'b0100, 1'b0));
    chk("pre_reset_ready_in", ready_in, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid_out", valid_out, 1'b0);
    chk("arst_outputs", {data1_out, data2_out, select_ula_out, illegal_out}, '0);
    chk("arst_ready_in", ready_in, 1'b1);
    exp_q.delete();
    idle(1);
    reset_n = 1'b1;
    base = pop_cyc.size();
    ready_out = 1'b1;
    idle(3);
    chk("arst_nothing_emitted", pop_cyc.size() - base, 0);
    send(7'b0110011, 3'b011, 1'b0, 32'h1, 32'hFFFFFFFF, '0, '0,
         pk(32'h1, 32'hFFFFFFFF, 4'b0101, 1'b0));
    idle(3);

    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule
